// File: rtl/pipe_stage_elastic_pkg.sv
// Shared constants and state encoding for the elastic pipeline-stage registers.
package pipe_stage_elastic_pkg;

  localparam logic [31:0] PIPE_NOP = 32'h0000_0000;  // MIPS sll $0,$0,0

  localparam int unsigned IF_ID_W = 64;               // {pc_plus_4, inst}

  // Encoding mirrors {out_valid, skid_valid}.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } stage_state_e;

endpackage

// File: rtl/pipe_stage_elastic_sat_counter.sv
// Saturating up-counter used for pipeline-stage performance monitoring.
module pipe_sat_counter #(
  parameter int unsigned PERF_W = 32
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              inc,
  output logic [PERF_W-1:0] count
);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + PERF_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register: valid/ready handshake, 2-entry skid buffer,
// synchronous flush. Define PIPE_STAGE_PERF_EN to enable stall/bubble counters.
module pipe_stage_elastic
  import pipe_stage_elastic_pkg::*;
#(
  parameter int unsigned           WIDTH  = 64,
  parameter logic [WIDTH-1:0]      BUBBLE = WIDTH'(PIPE_NOP),
  parameter int unsigned           PERF_W = 32
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] bubble_cnt
);

  stage_state_e     state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire, out_fire;

  // in_ready comes straight from the state flop, so no combinational ready path.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= EMPTY;
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (out_fire && in_fire) begin
            main_d = in_data;
          end else if (out_fire) begin
            state_d = EMPTY;
            main_d  = BUBBLE;
          end else if (in_fire) begin
            state_d = FULL;
            skid_d  = in_data;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = BUBBLE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = BUBBLE;
          skid_d  = BUBBLE;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  pipe_sat_counter #(.PERF_W(PERF_W)) u_stall_cnt (
    .clock  (clock),
    .resetn (resetn),
    .inc    (out_valid & ~out_ready),
    .count  (stall_cnt)
  );

  pipe_sat_counter #(.PERF_W(PERF_W)) u_bubble_cnt (
    .clock  (clock),
    .resetn (resetn),
    .inc    (~out_valid),
    .count  (bubble_cnt)
  );
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic: queue-based reference model plus
// directed scenarios and randomized traffic.
module tb_pipe_stage_elastic;
  localparam int unsigned WIDTH  = 32;
  localparam logic [31:0] BUBBLE = 32'h0BAD_F00D;
  localparam int unsigned PERF_W = 4;
  localparam int          MAXC   = (1 << PERF_W) - 1;
`ifdef PIPE_STAGE_PERF_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              resetn;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [PERF_W-1:0] stall_cnt;
  logic [PERF_W-1:0] bubble_cnt;

  int checks = 0;
  int errors = 0;

  pipe_stage_elastic #(.WIDTH(WIDTH), .BUBBLE(BUBBLE), .PERF_W(PERF_W)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the stage is a FIFO of at most two payloads.
  logic [WIDTH-1:0] q[$];
  int m_stall, m_bub;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      q.delete();
      m_stall = 0;
      m_bub   = 0;
    end else begin
      bit can_take, can_give;
      can_take = in_valid && (q.size() < 2);
      can_give = (q.size() > 0) && out_ready;
      if (q.size() == 0 && m_bub != MAXC) m_bub++;
      if (q.size() > 0 && !out_ready && m_stall != MAXC) m_stall++;
      if (flush) begin
        q.delete();
      end else begin
        if (can_give) void'(q.pop_front());
        if (can_take) q.push_back(in_data);
      end
    end
  end

  always @(negedge clock) begin
    logic [WIDTH-1:0] exp_data;
    exp_data = (q.size() > 0) ? q[0] : BUBBLE;
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("out_data", 64'(out_data), 64'(exp_data));
    chk("stall_cnt", 64'(stall_cnt), PERF_EN ? 64'(m_stall) : 64'd0);
    chk("bubble_cnt", 64'(bubble_cnt), PERF_EN ? 64'(m_bub) : 64'd0);
  end

  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'(BUBBLE));
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    resetn = 1'b1;

    // 1. idle
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk("idle_bubble_cnt", 64'(bubble_cnt), PERF_EN ? 64'd10 : 64'd0);
    chk("idle_out_data", 64'(out_data), 64'(BUBBLE));

    // 2. streaming
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, WIDTH'(i), 1'b1, 1'b0);
      chk("stream_data", 64'(out_data), 64'(i));
      chk("stream_in_ready", 64'(in_ready), 64'd1);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    chk("stream_drain", 64'(out_valid), 64'd0);

    // 3. backpressure
    step(1'b1, 32'hA, 1'b0, 1'b0);
    step(1'b1, 32'hB, 1'b0, 1'b0);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_hold_A", 64'(out_data), 64'hA);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("bp_out_B", 64'(out_data), 64'hB);
    chk("bp_ready_back", 64'(in_ready), 64'd1);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("bp_empty", 64'(out_data), 64'(BUBBLE));

    // 4. flush while full
    step(1'b1, 32'hA, 1'b0, 1'b0);
    step(1'b1, 32'hB, 1'b0, 1'b0);
    step(1'b1, 32'hC, 1'b0, 1'b1);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_data", 64'(out_data), 64'(BUBBLE));
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      chk("flush_no_output", 64'(out_valid), 64'd0);
    end

    // 5. async reset mid-stream
    step(1'b1, 32'hD, 1'b0, 1'b0);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_data", 64'(out_data), 64'(BUBBLE));
    in_valid = 1'b0;
    @(negedge clock);
    resetn = 1'b1;

    // 6. stall counter saturation
    step(1'b1, 32'hE, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0, 1'b0);
    chk("sat_stall_cnt", 64'(stall_cnt), PERF_EN ? 64'd15 : 64'd0);
    chk("sat_hold_data", 64'(out_data), 64'hE);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 9) < 6,
           $urandom_range(0, 15) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
